// File: rtl/lc3_execute_pkg.sv
// Shared encodings for the LC3 execute stage: opcodes, E_Control field layout
// and the operand/address selector codes.
package lc3_exec_pkg;

   localparam int DW = 16;
   localparam int RW = 3;

   typedef enum logic [3:0] {
      OP_BR   = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_LD   = 4'b0010,
      OP_ST   = 4'b0011,
      OP_JSR  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_LDR  = 4'b0110,
      OP_STR  = 4'b0111,
      OP_RTI  = 4'b1000,
      OP_NOT  = 4'b1001,
      OP_LDI  = 4'b1010,
      OP_STI  = 4'b1011,
      OP_JMP  = 4'b1100,
      OP_RES  = 4'b1101,
      OP_LEA  = 4'b1110,
      OP_TRAP = 4'b1111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_ZERO = 2'b11
   } alu_ctl_e;

   typedef enum logic [1:0] {
      PC1_OFF11 = 2'b00,
      PC1_OFF9  = 2'b01,
      PC1_OFF6  = 2'b10,
      PC1_ZERO  = 2'b11
   } pcsel1_e;

   localparam logic PC2_NPC = 1'b1;
   localparam logic OP2_REG = 1'b1;

   // E_Control = {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
   function automatic alu_ctl_e alu_ctl_of(input logic [5:0] e);
      return alu_ctl_e'(e[5:4]);
   endfunction

   function automatic pcsel1_e pcsel1_of(input logic [5:0] e);
      return pcsel1_e'(e[3:2]);
   endfunction

   function automatic logic pcsel2_of(input logic [5:0] e);
      return e[1];
   endfunction

   function automatic logic op2sel_of(input logic [5:0] e);
      return e[0];
   endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// decode_out bus from the decode stage into execute.
// There is no valid/ready pair: the execute stage samples every field on a rising
// clock edge whenever enable_execute is high, and ignores the bus otherwise.
interface lc3_execute_if;
   import lc3_exec_pkg::*;

   logic [1:0]    W_Control_in;
   logic [5:0]    E_Control;
   logic [DW-1:0] IR;
   logic [DW-1:0] npc_in;
   logic          Mem_Control_in;

   modport master (
      output W_Control_in, E_Control, IR, npc_in, Mem_Control_in
   );

   modport slave (
      input W_Control_in, E_Control, IR, npc_in, Mem_Control_in
   );
endinterface

// File: rtl/lc3_execute_alu.sv
// Combinational ALU and address adder of the execute stage; operands arrive
// already bypass-resolved.
module lc3_exec_alu
   import lc3_exec_pkg::*;
(
   input  logic [DW-1:0] op1,
   input  logic [DW-1:0] op2,
   input  logic [5:0]    e_control,
   input  logic [10:0]   ir_off,
   input  logic [DW-1:0] npc,
   output logic [DW-1:0] alu_res,
   output logic [DW-1:0] addr
);

   logic [DW-1:0] alu_b;
   logic [DW-1:0] pc_a;
   logic [DW-1:0] pc_b;

   always_comb begin
      alu_b = (op2sel_of(e_control) == OP2_REG) ? op2
                                               : {{(DW-5){ir_off[4]}}, ir_off[4:0]};
      alu_res = '0;
      case (alu_ctl_of(e_control))
         ALU_ADD:  alu_res = op1 + alu_b;
         ALU_AND:  alu_res = op1 & alu_b;
         ALU_NOT:  alu_res = ~op1;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      pc_a = '0;
      case (pcsel1_of(e_control))
         PC1_OFF11: pc_a = {{(DW-11){ir_off[10]}}, ir_off[10:0]};
         PC1_OFF9:  pc_a = {{(DW-9){ir_off[8]}}, ir_off[8:0]};
         PC1_OFF6:  pc_a = {{(DW-6){ir_off[5]}}, ir_off[5:0]};
         default:   pc_a = '0;
      endcase
      pc_b = (pcsel2_of(e_control) == PC2_NPC) ? npc : op1;
      // Carry out of bit 15 is intentionally dropped: addresses wrap at 2^16.
      addr = pc_a + pc_b;
   end

endmodule

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand bypass, ALU/address computation and the single
// pipeline register bank feeding memaccess/writeback.
module lc3_execute
   import lc3_exec_pkg::*;
#(
   parameter int DW_P = DW,
   parameter int RW_P = RW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_execute,
   lc3_execute_if.slave     dec_bus,
   input  logic [DW_P-1:0]  VSR1,
   input  logic [DW_P-1:0]  VSR2,
   input  logic             bypass_alu_1,
   input  logic             bypass_alu_2,
   input  logic             bypass_mem_1,
   input  logic             bypass_mem_2,
   input  logic [DW_P-1:0]  Mem_Bypass_Val,
   output logic [1:0]       W_Control_out,
   output logic             Mem_Control_out,
   output logic [DW_P-1:0]  aluout,
   output logic [DW_P-1:0]  pcout,
   output logic [RW_P-1:0]  dr,
   output logic [RW_P-1:0]  sr1,
   output logic [RW_P-1:0]  sr2,
   output logic [DW_P-1:0]  IR_Exec,
   output logic [2:0]       NZP,
   output logic [DW_P-1:0]  M_Data
);

   opcode_e         opcode;
   logic [DW_P-1:0] op1;
   logic [DW_P-1:0] op2;
   logic [DW_P-1:0] alu_res;
   logic [DW_P-1:0] addr;
   logic            is_alu_op;
   logic [RW_P-1:0] dr_next;
   logic [2:0]      nzp_next;

   assign opcode = opcode_e'(dec_bus.IR[15:12]);

   // Stores read their data register through sr2 from the dr field.
   always_comb begin
      sr1 = dec_bus.IR[8:6];
      if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI)
         sr2 = dec_bus.IR[11:9];
      else
         sr2 = dec_bus.IR[2:0];
   end

   // aluout fed back here is the pre-edge registered value, so a held stage
   // keeps forwarding the same result.
   always_comb begin
      op1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
      op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
   end

   lc3_exec_alu u_alu (
      .op1       (op1),
      .op2       (op2),
      .e_control (dec_bus.E_Control),
      .ir_off    (dec_bus.IR[10:0]),
      .npc       (dec_bus.npc_in),
      .alu_res   (alu_res),
      .addr      (addr)
   );

   always_comb begin
      is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
      dr_next   = '0;
      nzp_next  = 3'b000;
      case (opcode)
         OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA:
            dr_next = dec_bus.IR[11:9];
         default:
            dr_next = '0;
      endcase
      case (opcode)
         OP_BR:   nzp_next = dec_bus.IR[11:9];
         OP_JMP:  nzp_next = 3'b111;
         default: nzp_next = 3'b000;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         W_Control_out   <= '0;
         Mem_Control_out <= 1'b0;
         aluout          <= '0;
         pcout           <= '0;
         dr              <= '0;
         IR_Exec         <= '0;
         NZP             <= '0;
         M_Data          <= '0;
      end else if (enable_execute) begin
         W_Control_out   <= dec_bus.W_Control_in;
         Mem_Control_out <= dec_bus.Mem_Control_in;
         aluout          <= is_alu_op ? alu_res : addr;
         pcout           <= addr;
         dr              <= dr_next;
         IR_Exec         <= dec_bus.IR;
         NZP             <= nzp_next;
         M_Data          <= op2;
      end
   end

endmodule

// File: tb/tb_lc3_execute.sv
// Directed bench for lc3_execute: expected register-bank contents are queued as
// each instruction is driven and compared one cycle later.
module tb_lc3_execute;

   logic        clock;
   logic        reset;
   logic        enable_execute;
   logic [15:0] VSR1, VSR2, Mem_Bypass_Val;
   logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
   logic [1:0]  W_Control_out;
   logic        Mem_Control_out;
   logic [15:0] aluout, pcout, IR_Exec, M_Data;
   logic [2:0]  dr, sr1, sr2, NZP;

   lc3_execute_if dec_bus ();

   lc3_execute dut (
      .clock           (clock),
      .reset           (reset),
      .enable_execute  (enable_execute),
      .dec_bus         (dec_bus.slave),
      .VSR1            (VSR1),
      .VSR2            (VSR2),
      .bypass_alu_1    (bypass_alu_1),
      .bypass_alu_2    (bypass_alu_2),
      .bypass_mem_1    (bypass_mem_1),
      .bypass_mem_2    (bypass_mem_2),
      .Mem_Bypass_Val  (Mem_Bypass_Val),
      .W_Control_out   (W_Control_out),
      .Mem_Control_out (Mem_Control_out),
      .aluout          (aluout),
      .pcout           (pcout),
      .dr              (dr),
      .sr1             (sr1),
      .sr2             (sr2),
      .IR_Exec         (IR_Exec),
      .NZP             (NZP),
      .M_Data          (M_Data)
   );

   typedef struct packed {
      logic [15:0] aluout;
      logic [15:0] pcout;
      logic [15:0] mdata;
      logic [15:0] ir;
      logic [2:0]  dr;
      logic [2:0]  nzp;
      logic [1:0]  w;
      logic        mem;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   n_cmp = 0;
   int   n_err = 0;

   // clock/reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s mismatched", tag);
      end
   endtask

   // driver tasks
   task automatic drive(input logic [15:0] ir, input logic [5:0] ectl,
                        input logic [15:0] v1, input logic [15:0] v2,
                        input logic [15:0] npc, input logic [1:0] w, input logic mem);
      dec_bus.IR             = ir;
      dec_bus.E_Control      = ectl;
      dec_bus.npc_in         = npc;
      dec_bus.W_Control_in   = w;
      dec_bus.Mem_Control_in = mem;
      VSR1 = v1;
      VSR2 = v2;
   endtask

   task automatic bypass(input logic a1, input logic m1, input logic a2, input logic m2,
                         input logic [15:0] mval);
      bypass_alu_1   = a1;
      bypass_mem_1   = m1;
      bypass_alu_2   = a2;
      bypass_mem_2   = m2;
      Mem_Bypass_Val = mval;
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] p, input logic [15:0] md,
                       input logic [15:0] ir, input logic [2:0] d, input logic [2:0] n,
                       input logic [1:0] w, input logic mem);
      exp_t e;
      e.aluout = a; e.pcout = p; e.mdata = md; e.ir = ir;
      e.dr = d; e.nzp = n; e.w = w; e.mem = mem;
      exp_q.push_back(e);
      last_exp = e;
   endtask

   // scoreboard: one entry consumed per clock edge
   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
         n_err++;
         $display("FAIL queue: observed empty expected entry");
         $error("scoreboard empty");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("aluout", aluout, e.aluout);
         chk("pcout", pcout, e.pcout);
         chk("M_Data", M_Data, e.mdata);
         chk("IR_Exec", IR_Exec, e.ir);
         chk("dr", {13'd0, dr}, {13'd0, e.dr});
         chk("NZP", {13'd0, NZP}, {13'd0, e.nzp});
         chk("W_Control_out", {14'd0, W_Control_out}, {14'd0, e.w});
         chk("Mem_Control_out", {15'd0, Mem_Control_out}, {15'd0, e.mem});
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_aluout"}, aluout, 16'h0000);
      chk({tag, "_pcout"}, pcout, 16'h0000);
      chk({tag, "_M_Data"}, M_Data, 16'h0000);
      chk({tag, "_IR_Exec"}, IR_Exec, 16'h0000);
      chk({tag, "_dr"}, {13'd0, dr}, 16'h0000);
      chk({tag, "_NZP"}, {13'd0, NZP}, 16'h0000);
      chk({tag, "_W"}, {14'd0, W_Control_out}, 16'h0000);
      chk({tag, "_Mem"}, {15'd0, Mem_Control_out}, 16'h0000);
   endtask

   initial begin
      reset = 1'b1;
      enable_execute = 1'b1;
      drive(16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
      bypass(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      #2;
      check_zero("rst_init");
      @(negedge clock);
      reset = 1'b0;

      // ADD register form
      drive(16'h1042, 6'b000001, 16'h0005, 16'h0007, 16'h3000, 2'b01, 1'b0);
      #1;
      chk("sr1_add", {13'd0, sr1}, 16'd1);
      chk("sr2_add", {13'd0, sr2}, 16'd2);
      push(16'h000C, 16'h0047, 16'h0007, 16'h1042, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // ADD immediate -1 wraps to zero
      drive(16'h127F, 6'b000000, 16'h0001, 16'h1234, 16'h3000, 2'b10, 1'b0);
      #1;
      chk("sr2_imm", {13'd0, sr2}, 16'd7);
      push(16'h0000, 16'h0280, 16'h1234, 16'h127F, 3'd1, 3'b000, 2'b10, 1'b0);
      tick();

      // NOT
      drive(16'h927F, 6'b100000, 16'h00FF, 16'h0000, 16'h3000, 2'b01, 1'b0);
      push(16'hFF00, 16'h037E, 16'h0000, 16'h927F, 3'd1, 3'b000, 2'b01, 1'b0);
      tick();

      // AND register form
      drive(16'h5042, 6'b010001, 16'hF0F0, 16'h3C3C, 16'h3000, 2'b11, 1'b0);
      push(16'h3030, 16'hF132, 16'h3C3C, 16'h5042, 3'd0, 3'b000, 2'b11, 1'b0);
      tick();

      // alu_control 11 gives zero
      drive(16'h1042, 6'b110001, 16'h0005, 16'h0007, 16'h3000, 2'b01, 1'b0);
      push(16'h0000, 16'h0047, 16'h0007, 16'h1042, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // BR relative to npc
      drive(16'h0A05, 6'b000110, 16'h0000, 16'h0000, 16'h3001, 2'b00, 1'b0);
      push(16'h3006, 16'h3006, 16'h0000, 16'h0A05, 3'd0, 3'b101, 2'b00, 1'b0);
      tick();

      // BR with pcselect2=0 adds to op1
      drive(16'h0A05, 6'b000100, 16'h1000, 16'h0000, 16'h3001, 2'b00, 1'b0);
      push(16'h1005, 16'h1005, 16'h0000, 16'h0A05, 3'd0, 3'b101, 2'b00, 1'b0);
      tick();

      // address wrap 0xFFFF + 1
      drive(16'h0E01, 6'b000110, 16'h0000, 16'h0000, 16'hFFFF, 2'b00, 1'b0);
      push(16'h0000, 16'h0000, 16'h0000, 16'h0E01, 3'd0, 3'b111, 2'b00, 1'b0);
      tick();

      // JMP: zero offset + base register
      drive(16'hC1C0, 6'b001100, 16'h4321, 16'h0000, 16'h3000, 2'b00, 1'b0);
      push(16'h4321, 16'h4321, 16'h0000, 16'hC1C0, 3'd0, 3'b111, 2'b00, 1'b0);
      tick();

      // LEA, negative PCoffset9
      drive(16'hEFFE, 6'b000110, 16'h0000, 16'h0000, 16'h3000, 2'b01, 1'b0);
      push(16'h2FFE, 16'h2FFE, 16'h0000, 16'hEFFE, 3'd7, 3'b000, 2'b01, 1'b0);
      tick();

      // ADD imm 1 to set aluout = 0x0010
      drive(16'h1061, 6'b000000, 16'h000F, 16'h0000, 16'h3000, 2'b01, 1'b0);
      push(16'h0010, 16'h0070, 16'h0000, 16'h1061, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // both bypasses on op1: alu bypass wins
      drive(16'h1061, 6'b000000, 16'h0500, 16'h0000, 16'h3000, 2'b01, 1'b0);
      bypass(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
      push(16'h0011, 16'h0071, 16'h0000, 16'h1061, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // mem bypass on op2
      drive(16'h1042, 6'b000001, 16'h0002, 16'h9999, 16'h3000, 2'b01, 1'b0);
      bypass(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
      push(16'h0102, 16'h0044, 16'h0100, 16'h1042, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // STR: sr2 from IR[11:9], store data on M_Data
      drive(16'h7A46, 6'b001001, 16'h4000, 16'hBEEF, 16'h3000, 2'b00, 1'b1);
      bypass(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk("sr1_str", {13'd0, sr1}, 16'd1);
      chk("sr2_str", {13'd0, sr2}, 16'd5);
      push(16'h4006, 16'h4006, 16'hBEEF, 16'h7A46, 3'd0, 3'b000, 2'b00, 1'b1);
      tick();

      // hold for three cycles with changing inputs
      enable_execute = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(16'($urandom_range(0, 16'hFFFF)), 6'($urandom_range(0, 63)),
               16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
               16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), 1'b0);
         bypass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                16'($urandom_range(0, 16'hFFFF)));
         push(last_exp.aluout, last_exp.pcout, last_exp.mdata, last_exp.ir,
              last_exp.dr, last_exp.nzp, last_exp.w, last_exp.mem);
         tick();
      end

      // resume: op2 bypass takes the held aluout
      enable_execute = 1'b1;
      drive(16'h1042, 6'b000001, 16'h0001, 16'h7777, 16'h3000, 2'b01, 1'b0);
      bypass(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      push(16'h4007, 16'h0043, 16'h4006, 16'h1042, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      // asynchronous reset mid-cycle
      #3;
      reset = 1'b1;
      #1;
      check_zero("rst_mid");
      #1;
      reset = 1'b0;

      // after reset, alu bypass feeds the cleared aluout
      drive(16'h1061, 6'b000000, 16'h0500, 16'h0000, 16'h3000, 2'b01, 1'b0);
      bypass(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      push(16'h0001, 16'h0061, 16'h0000, 16'h1061, 3'd0, 3'b000, 2'b01, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
